// File: rtl/rbt_s_hdr_deparser.sv
// Header deparser: writes the PHV property byte back into a parsed header and serializes it as AXI-Stream beats.
// Optional drop-flag handling is enabled by defining RBT_S_DEPARSER_DROP_EN.
`timescale 1ns/1ps
module rbt_s_hdr_deparser #(
    parameter int HEADER_WIDTH         = 2048,
    parameter int PHV_WIDTH            = 408,
    parameter int DATA_WIDTH           = 512,
    parameter int KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int PROPERTY_BYTE_OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_proto_hdr_valid,
    output logic                    in_proto_hdr_ready,
    input  logic [15:0]             in_proto_hdr_length,
    input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
    input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [PHV_WIDTH-1:0]    m_axis_phv,
    output logic [31:0]             drop_count
);
    localparam int HDR_BYTES = HEADER_WIDTH / 8;
    localparam int MAX_BEATS = HEADER_WIDTH / DATA_WIDTH;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, next_state;

    logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] hdr_reg;
    logic [PHV_WIDTH-1:0]                 phv_reg;
    logic [BEAT_W-1:0]                    beat_idx;
    logic [BEAT_W-1:0]                    last_idx;
    logic [KEEP_WIDTH-1:0]                last_keep;
    logic [31:0]                          count_reg;

    logic [15:0]             eff_len;
    logic [15:0]             eff_len_m1;
    logic [15:0]             rem_bytes;
    logic [BEAT_W-1:0]       load_last_idx;
    logic [KEEP_WIDTH-1:0]   load_keep;
    logic [HEADER_WIDTH-1:0] load_hdr;
    logic                    drop_hdr;
    logic                    at_last;
    logic                    load;
    logic                    advance;
    logic                    drop;

    // Over-long headers are silently truncated to the blob size.
    assign eff_len       = (32'(in_proto_hdr_length) > HDR_BYTES) ? 16'(HDR_BYTES) : in_proto_hdr_length;
    assign eff_len_m1    = eff_len - 16'd1;
    assign load_last_idx = BEAT_W'(eff_len_m1 / 16'(KEEP_WIDTH));
    assign rem_bytes     = (eff_len_m1 % 16'(KEEP_WIDTH)) + 16'd1;
    assign load_keep     = {KEEP_WIDTH{1'b1}} >> (16'(KEEP_WIDTH) - rem_bytes);

`ifdef RBT_S_DEPARSER_DROP_EN
    assign drop_hdr = (eff_len == 16'd0) || in_proto_hdr_phv[14];
`else
    assign drop_hdr = (eff_len == 16'd0);
`endif

    always_comb begin
        load_hdr = in_proto_hdr_data;
        load_hdr[PROPERTY_BYTE_OFFSET*8 +: 8] = in_proto_hdr_phv[7:0];
    end

    assign at_last = (beat_idx == last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A header may be taken in the same cycle the previous last beat leaves.
    always_comb begin
        next_state         = state;
        in_proto_hdr_ready = 1'b0;
        load               = 1'b0;
        advance            = 1'b0;
        drop               = 1'b0;
        case (state)
            IDLE: begin
                in_proto_hdr_ready = 1'b1;
            end
            SEND: begin
                in_proto_hdr_ready = m_axis_tready && at_last;
                if (m_axis_tready) begin
                    if (at_last) begin
                        next_state = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (in_proto_hdr_valid && in_proto_hdr_ready) begin
            if (drop_hdr) begin
                drop = 1'b1;
            end else begin
                load       = 1'b1;
                next_state = SEND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg   <= '0;
            phv_reg   <= '0;
            beat_idx  <= '0;
            last_idx  <= '0;
            last_keep <= '0;
            count_reg <= '0;
        end else begin
            if (load) begin
                hdr_reg   <= load_hdr;
                phv_reg   <= in_proto_hdr_phv;
                beat_idx  <= '0;
                last_idx  <= load_last_idx;
                last_keep <= load_keep;
            end else if (advance) begin
                beat_idx <= beat_idx + BEAT_W'(1);
            end
            if (drop) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tlast  = (state == SEND) && at_last;
    assign m_axis_tkeep  = (state != SEND) ? '0 : (at_last ? last_keep : '1);
    assign m_axis_tdata  = hdr_reg[beat_idx];
    assign m_axis_phv    = phv_reg;
    assign drop_count    = count_reg;

endmodule

// File: tb/tb_rbt_s_hdr_deparser.sv
// Testbench for rbt_s_hdr_deparser: directed and random headers checked against a byte-level
// reference model; follows RBT_S_DEPARSER_DROP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rbt_s_hdr_deparser;
    localparam int HEADER_WIDTH = 2048;
    localparam int PHV_WIDTH    = 408;
    localparam int DATA_WIDTH   = 512;
    localparam int KEEP_WIDTH   = DATA_WIDTH / 8;
    localparam int PROP_OFF     = 0;
    localparam int HDR_BYTES    = HEADER_WIDTH / 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_proto_hdr_valid = 1'b0;
    logic                    in_proto_hdr_ready;
    logic [15:0]             in_proto_hdr_length = '0;
    logic [PHV_WIDTH-1:0]    in_proto_hdr_phv = '0;
    logic [HEADER_WIDTH-1:0] in_proto_hdr_data = '0;
    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [KEEP_WIDTH-1:0]   m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready = 1'b0;
    logic                    m_axis_tlast;
    logic [PHV_WIDTH-1:0]    m_axis_phv;
    logic [31:0]             drop_count;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [PHV_WIDTH-1:0]  phv;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] exp_drops = '0;
    bit          accepted = 1'b0;
    int          tready_pct = 100;
    int          checks_total = 0;
    int          checks_passed = 0;

    rbt_s_hdr_deparser #(
        .HEADER_WIDTH(HEADER_WIDTH),
        .PHV_WIDTH(PHV_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .PROPERTY_BYTE_OFFSET(PROP_OFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_proto_hdr_valid(in_proto_hdr_valid),
        .in_proto_hdr_ready(in_proto_hdr_ready),
        .in_proto_hdr_length(in_proto_hdr_length),
        .in_proto_hdr_phv(in_proto_hdr_phv),
        .in_proto_hdr_data(in_proto_hdr_data),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_phv(m_axis_phv),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expectation and tally the result.
    task automatic checkValue(input string tag, input logic [HEADER_WIDTH-1:0] obs,
                              input logic [HEADER_WIDTH-1:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HEADER_WIDTH-1:0] randData();
        logic [HEADER_WIDTH-1:0] d;
        for (int i = 0; i < HEADER_WIDTH / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [PHV_WIDTH-1:0] randPhv();
        logic [PHV_WIDTH-1:0] p;
        for (int i = 0; i < PHV_WIDTH / 8; i++) p[8*i +: 8] = 8'($urandom);
        return p;
    endfunction

    // Reference: cut the header into byte-addressed beats from the length rules alone.
    task automatic modelAccept();
        logic [7:0]            hdr_bytes [HDR_BYTES];
        int                    eff, nbeats, nb;
        bit                    is_drop;
        beat_t                 b;
        for (int n = 0; n < HDR_BYTES; n++) hdr_bytes[n] = in_proto_hdr_data[8*n +: 8];
        hdr_bytes[PROP_OFF] = in_proto_hdr_phv[7:0];
        eff = (int'(in_proto_hdr_length) > HDR_BYTES) ? HDR_BYTES : int'(in_proto_hdr_length);
        is_drop = (eff == 0);
`ifdef RBT_S_DEPARSER_DROP_EN
        if (in_proto_hdr_phv[14]) is_drop = 1'b1;
`endif
        if (is_drop) begin
            exp_drops = exp_drops + 32'd1;
            return;
        end
        nbeats = (eff + KEEP_WIDTH - 1) / KEEP_WIDTH;
        for (int k = 0; k < nbeats; k++) begin
            for (int j = 0; j < KEEP_WIDTH; j++) b.data[8*j +: 8] = hdr_bytes[k*KEEP_WIDTH + j];
            nb = eff - k * KEEP_WIDTH;
            if (nb > KEEP_WIDTH) nb = KEEP_WIDTH;
            b.keep = '0;
            for (int j = 0; j < nb; j++) b.keep[j] = 1'b1;
            b.last = (k == nbeats - 1);
            b.phv  = in_proto_hdr_phv;
            beat_q.push_back(b);
        end
    endtask

    task automatic checkOutput();
        logic exp_valid;
        logic exp_ready;
        if (rst) begin
            beat_q.delete();
            exp_drops = '0;
            return;
        end
        exp_valid = (beat_q.size() != 0);
        exp_ready = 1'b1;
        if (exp_valid) exp_ready = m_axis_tready && beat_q[0].last;
        checkValue("tvalid", m_axis_tvalid, exp_valid);
        checkValue("hdr_ready", in_proto_hdr_ready, exp_ready);
        checkValue("drop_count", drop_count, exp_drops);
        if (exp_valid) begin
            checkValue("tdata", m_axis_tdata, beat_q[0].data);
            checkValue("tkeep", m_axis_tkeep, beat_q[0].keep);
            checkValue("tlast", m_axis_tlast, beat_q[0].last);
            checkValue("phv", m_axis_phv, beat_q[0].phv);
            if (m_axis_tready) void'(beat_q.pop_front());
        end
        if (in_proto_hdr_valid && exp_ready) begin
            modelAccept();
            accepted = 1'b1;
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int len, input logic [PHV_WIDTH-1:0] phv,
                                 input logic [HEADER_WIDTH-1:0] data);
        in_proto_hdr_valid  = 1'b1;
        in_proto_hdr_length = 16'(len);
        in_proto_hdr_phv    = phv;
        in_proto_hdr_data   = data;
        accepted = 1'b0;
        for (int c = 0; c < 100 && !accepted; c++) begin
            m_axis_tready = ($urandom_range(99) < tready_pct);
            stepCycle();
        end
        checkValue("accept_timeout", accepted, 1'b1);
        in_proto_hdr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && beat_q.size() != 0; c++) begin
            m_axis_tready = ($urandom_range(99) < tready_pct);
            stepCycle();
        end
        checkValue("drain_timeout", 32'(beat_q.size()), 32'd0);
        stepCycle();
    endtask

    function automatic logic [PHV_WIDTH-1:0] keepPhv(input logic [7:0] byte0);
        logic [PHV_WIDTH-1:0] p;
        p = randPhv();
        p[7:0] = byte0;
        p[14]  = 1'b0;
        return p;
    endfunction

    initial begin
        logic [PHV_WIDTH-1:0] p;
        int                   len;
        int                   gap;

        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        checkValue("reset_tvalid", m_axis_tvalid, 1'b0);
        checkValue("reset_tlast", m_axis_tlast, 1'b0);
        checkValue("reset_tdata", m_axis_tdata, {DATA_WIDTH{1'b0}});
        checkValue("reset_tkeep", m_axis_tkeep, {KEEP_WIDTH{1'b0}});
        checkValue("reset_phv", m_axis_phv, {PHV_WIDTH{1'b0}});
        checkValue("reset_drops", drop_count, 32'd0);

        $display("[TB] length 100 with property byte 0x0D");
        tready_pct = 100;
        applyStimulus(100, keepPhv(8'h0D), randData());
        checkValue("byte0_property", m_axis_tdata[7:0], 8'h0D);
        drain();

        $display("[TB] back-to-back lengths 256 and 64");
        applyStimulus(256, keepPhv(8'($urandom)), randData());
        applyStimulus(64, keepPhv(8'($urandom)), randData());
        drain();

        $display("[TB] length 128 with a stall on beat 1");
        applyStimulus(128, keepPhv(8'($urandom)), randData());
        m_axis_tready = 1'b1;
        stepCycle();
        m_axis_tready = 1'b0;
        stepCycle();
        m_axis_tready = 1'b1;
        stepCycle();
        drain();

        $display("[TB] zero length then truncated length 300");
        applyStimulus(0, keepPhv(8'($urandom)), randData());
        checkValue("zero_len_drops", drop_count, 32'd1);
        applyStimulus(300, keepPhv(8'($urandom)), randData());
        drain();

        $display("[TB] reset during beat 2 of a 4-beat header");
        applyStimulus(256, keepPhv(8'($urandom)), randData());
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        applyStimulus(64, keepPhv(8'($urandom)), randData());
        drain();

        $display("[TB] drop flag in PHV byte 1");
        p = randPhv();
        p[15:8] = 8'h40;
        applyStimulus(64, p, randData());
        drain();
`ifdef RBT_S_DEPARSER_DROP_EN
        checkValue("drop_flag_count", drop_count, 32'd1);
`else
        checkValue("drop_flag_count", drop_count, 32'd0);
`endif

        $display("[TB] random headers with random backpressure");
        tready_pct = 70;
        for (int h = 0; h < 30; h++) begin
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(320, 1));
            applyStimulus(len, randPhv(), randData());
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++) begin
                m_axis_tready = ($urandom_range(99) < tready_pct);
                stepCycle();
            end
        end
        drain();

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
